// File: rtl/divider_seq.sv
// -----------------------------------------------------------------------------
// divider_seq
//
// Multi-cycle restoring divider for unsigned or two's-complement operands,
// with an optional fixed-point quotient (FIXED_POINT fractional bits) and
// UNROLL quotient bits resolved per cycle.
//
// The core always divides magnitudes. Signs are fixed up in a single cycle
// after the iterations. Divide-by-zero bypasses the iterations entirely.
//
// Ports
//   ctl_clk     in   1        clock, rising edge
//   reset       in   1        asynchronous, active-high reset
//   trigger     in   1        start request, sampled while ready=1
//   a           in   C_WIDTH  dividend
//   b           in   C_WIDTH  divisor
//   signed_cal  in   1        1 = two's-complement operands, 0 = unsigned
//   ready       out  1        able to accept trigger
//   done        out  1        one-cycle pulse, results valid
//   q           out  C_WIDTH  quotient
//   r           out  C_WIDTH  remainder
//   div_zero    out  1        last operation had b=0
//   overflow    out  1        last quotient did not fit in C_WIDTH
//
// States
//   state | meaning
//   IDLE  | waiting for trigger
//   CALC  | restoring iterations, UNROLL quotient bits per cycle
//   FIX   | apply signs, detect overflow, latch internal result
//   DONE  | result latched; outputs and done update on the exit edge,
//         | trigger accepted here for back-to-back operation
// -----------------------------------------------------------------------------
module divider_seq #(
   parameter int C_WIDTH     = 16,
   parameter int FIXED_POINT = 0,
   parameter int UNROLL      = 1
) (
   input  logic               ctl_clk,
   input  logic               reset,
   input  logic               trigger,
   input  logic [C_WIDTH-1:0] a,
   input  logic [C_WIDTH-1:0] b,
   input  logic               signed_cal,
   output logic               ready,
   output logic               done,
   output logic [C_WIDTH-1:0] q,
   output logic [C_WIDTH-1:0] r,
   output logic               div_zero,
   output logic               overflow
);

   localparam int W     = C_WIDTH;
   localparam int F     = FIXED_POINT;
   localparam int N     = W + F;
   localparam int ITER  = N / UNROLL;
   localparam int CNT_W = $clog2(ITER + 1);

   localparam logic [N-1:0]     S_MIN_MAG = N'(64'd1 << (W - 1));
   localparam logic [N-1:0]     S_MAX_MAG = S_MIN_MAG - N'(1);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(ITER - 1);
   localparam logic [W-1:0]     Q_MAX_POS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]     Q_MIN_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;
   state_t state_nx;

   logic accept;
   logic step;
   logic finish;
   logic b_zero;

   // quo starts as the zero-extended dividend magnitude and fills with
   // quotient bits from the LSB side as dividend bits shift out of the MSB.
   logic [N-1:0]     quo;
   logic [N-1:0]     quo_nx;
   logic [W-1:0]     rem;
   logic [W-1:0]     rem_nx;
   logic [W-1:0]     dvs;
   logic [CNT_W-1:0] cnt;
   logic             op_s;
   logic             neg_q;
   logic             neg_r;

   logic [W-1:0]     res_q;
   logic [W-1:0]     res_r;
   logic             res_dz;
   logic             res_ov;

   logic [W-1:0]     mag_a;
   logic [W-1:0]     mag_b;
   logic [W-1:0]     q_fin;
   logic [W-1:0]     r_fin;
   logic             ov_u;
   logic             ov_fin;

   logic [W:0]       trial;
   logic             qbit;

   assign b_zero = (b == '0);

   // The magnitude of the most negative value is 2^(W-1), which still fits
   // as an unsigned W-bit number, so no extra bit is needed.
   assign mag_a = (signed_cal && a[W-1]) ? W'(-a) : a;
   assign mag_b = (signed_cal && b[W-1]) ? W'(-b) : b;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge ctl_clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: begin
            if (trigger) begin
               state_nx = b_zero ? DONE : CALC;
            end else begin
               state_nx = IDLE;
            end
         end
         CALC: begin
            if (cnt == '0) begin
               state_nx = FIX;
            end
         end
         FIX:     state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ready  = 1'b0;
      step   = 1'b0;
      finish = 1'b0;
      case (state)
         IDLE, DONE: ready  = 1'b1;
         CALC:       step   = 1'b1;
         FIX:        finish = 1'b1;
         default:    ready  = 1'b0;
      endcase
   end

   assign accept = ready & trigger;

   // ------------------------------------------------------- restoring core
   always_comb begin
      rem_nx = rem;
      quo_nx = quo;
      trial  = '0;
      qbit   = 1'b0;
      for (int i = 0; i < UNROLL; i++) begin
         trial  = {rem_nx, quo_nx[N-1]};
         qbit   = (trial >= {1'b0, dvs});
         // rem < dvs going in, so trial - dvs < dvs and fits in W bits
         rem_nx = qbit ? W'(trial - {1'b0, dvs}) : trial[W-1:0];
         quo_nx = {quo_nx[N-2:0], qbit};
      end
   end

   // ---------------------------------------------------- sign fix / range
   assign q_fin = neg_q ? W'(-quo[W-1:0]) : quo[W-1:0];
   assign r_fin = neg_r ? W'(-rem) : rem;

   // Unsigned overflow is any quotient bit above the W-bit window, which
   // only exists when fractional bits widen the magnitude.
   generate
      if (F > 0) begin : g_frac_ov
         assign ov_u = |quo[N-1:W];
      end else begin : g_int_ov
         assign ov_u = 1'b0;
      end
   endgenerate

   // A negative result may reach magnitude 2^(W-1); a positive one only
   // 2^(W-1)-1. This also flags min / -1.
   assign ov_fin = op_s ? (neg_q ? (quo > S_MIN_MAG) : (quo > S_MAX_MAG))
                        : ov_u;

   // ------------------------------------------------------------ datapath
   always_ff @(posedge ctl_clk or posedge reset) begin
      if (reset) begin
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
         cnt    <= '0;
         op_s   <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         res_q  <= '0;
         res_r  <= '0;
         res_dz <= 1'b0;
         res_ov <= 1'b0;
      end else begin
         if (accept) begin
            op_s <= signed_cal;
            if (b_zero) begin
               res_q  <= signed_cal ? (a[W-1] ? Q_MIN_NEG : Q_MAX_POS) : '1;
               res_r  <= a;
               res_dz <= 1'b1;
               res_ov <= 1'b0;
            end else begin
               quo   <= N'(mag_a) << F;
               rem   <= '0;
               dvs   <= mag_b;
               neg_q <= signed_cal & (a[W-1] ^ b[W-1]);
               neg_r <= signed_cal & a[W-1];
               cnt   <= CNT_LOAD;
            end
         end else if (step) begin
            quo <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt - 1'b1;
         end else if (finish) begin
            res_q  <= q_fin;
            res_r  <= r_fin;
            res_dz <= 1'b0;
            res_ov <= ov_fin;
         end
      end
   end

   // Outputs are published on the edge that leaves DONE. A back-to-back
   // load on that same edge overwrites res_* only after the old values
   // have been copied out.
   always_ff @(posedge ctl_clk or posedge reset) begin
      if (reset) begin
         done     <= 1'b0;
         q        <= '0;
         r        <= '0;
         div_zero <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= (state == DONE);
         if (state == DONE) begin
            q        <= res_q;
            r        <= res_r;
            div_zero <= res_dz;
            overflow <= res_ov;
         end
      end
   end

endmodule

// File: tb/tb_divider_seq.sv
// Three divider instances (C_WIDTH=8) share one stimulus stream:
//   inst 0: F=0 UNROLL=1, inst 1: F=4 UNROLL=1, inst 2: F=0 UNROLL=4.
// Each instance has its own arithmetic reference model and timing schedule.
module tb_divider_seq;

   logic       clk        = 1'b0;
   logic       rst        = 1'b1;
   logic       trigger    = 1'b0;
   logic       signed_cal = 1'b0;
   logic [7:0] a          = 8'h00;
   logic [7:0] b          = 8'h00;

   logic       ready_w [3];
   logic       done_w  [3];
   logic       dz_w    [3];
   logic       ov_w    [3];
   logic [7:0] q_w     [3];
   logic [7:0] r_w     [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      divider_seq #(
         .C_WIDTH    (8),
         .FIXED_POINT((g == 1) ? 4 : 0),
         .UNROLL     ((g == 2) ? 4 : 1)
      ) u_dut (
         .ctl_clk   (clk),
         .reset     (rst),
         .trigger   (trigger),
         .a         (a),
         .b         (b),
         .signed_cal(signed_cal),
         .ready     (ready_w[g]),
         .done      (done_w[g]),
         .q         (q_w[g]),
         .r         (r_w[g]),
         .div_zero  (dz_w[g]),
         .overflow  (ov_w[g])
      );
   end

   typedef struct {
      int         idx;
      int         due;
      logic [7:0] q;
      logic [7:0] r;
      bit         dz;
      bit         ov;
   } pend_t;

   int         checks = 0;
   int         errors = 0;
   int         n      = 0;
   pend_t      pend[$];
   bit         m_ready  [3];
   int         busy_last[3];
   logic [7:0] hq [3];
   logic [7:0] hr [3];
   bit         hdz[3];
   bit         hov[3];

   task automatic chk(input string name, input int inst, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s inst%0d edge %0d: got 0x%0h, expected 0x%0h", name, inst, n, act, exp);
      end
   endtask

   function automatic int fp_of(input int i);
      return (i == 1) ? 4 : 0;
   endfunction

   function automatic int iter_of(input int i);
      return (8 + fp_of(i)) / ((i == 2) ? 4 : 1);
   endfunction

   // Plain-arithmetic reference: SV integer division truncates toward zero
   // and % takes the sign of the dividend, matching the required semantics.
   function automatic void ref_div(input int f, input logic [7:0] va, input logic [7:0] vb,
                                   input bit vs, output logic [7:0] eq, output logic [7:0] er,
                                   output bit edz, output bit eov);
      longint num, den, tq, tr;
      if (vb == 8'h00) begin
         edz = 1'b1;
         eov = 1'b0;
         er  = va;
         eq  = vs ? (va[7] ? 8'h80 : 8'h7F) : 8'hFF;
      end else begin
         num = vs ? longint'($signed(va)) : longint'(va);
         den = vs ? longint'($signed(vb)) : longint'(vb);
         num = num * (longint'(1) << f);
         tq  = num / den;
         tr  = num % den;
         eq  = tq[7:0];
         er  = tr[7:0];
         edz = 1'b0;
         eov = vs ? (tq > 127 || tq < -128) : (tq > 255);
      end
   endfunction

   function automatic void model_clear();
      pend.delete();
      for (int i = 0; i < 3; i++) begin
         m_ready[i]   = 1'b1;
         busy_last[i] = -100;
         hq[i]        = 8'h00;
         hr[i]        = 8'h00;
         hdz[i]       = 1'b0;
         hov[i]       = 1'b0;
      end
   endfunction

   initial model_clear();

   // Acceptance and scheduling at each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         n++;
         if (rst) begin
            model_clear();
         end else begin
            for (int i = 0; i < 3; i++) begin
               if (trigger && m_ready[i]) begin
                  pend_t      e;
                  logic [7:0] eq, er;
                  bit         edz, eov;
                  ref_div(fp_of(i), a, b, signed_cal, eq, er, edz, eov);
                  e.idx = i;
                  e.q   = eq;
                  e.r   = er;
                  e.dz  = edz;
                  e.ov  = eov;
                  e.due = n + ((b == 8'h00) ? 1 : iter_of(i) + 2);
                  pend.push_back(e);
                  if (b != 8'h00) busy_last[i] = n + iter_of(i);
               end
               m_ready[i] = (n > busy_last[i]);
            end
         end
      end
   end

   // Compare every output of every instance on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) model_clear();
         for (int i = 0; i < 3; i++) begin
            bit exp_done;
            exp_done = 1'b0;
            for (int j = pend.size() - 1; j >= 0; j--) begin
               if (pend[j].idx == i && pend[j].due <= n) begin
                  exp_done = 1'b1;
                  hq[i]    = pend[j].q;
                  hr[i]    = pend[j].r;
                  hdz[i]   = pend[j].dz;
                  hov[i]   = pend[j].ov;
                  pend.delete(j);
               end
            end
            chk("ready",    i, ready_w[i], m_ready[i]);
            chk("done",     i, done_w[i],  exp_done);
            chk("q",        i, q_w[i],     hq[i]);
            chk("r",        i, r_w[i],     hr[i]);
            chk("div_zero", i, dz_w[i],    hdz[i]);
            chk("overflow", i, ov_w[i],    hov[i]);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [7:0] va, input logic [7:0] vb, input bit vs);
      a          = va;
      b          = vb;
      signed_cal = vs;
      trigger    = 1'b1;
      cyc();
      trigger    = 1'b0;
      a          = 8'($urandom);
      b          = 8'($urandom);
      signed_cal = 1'($urandom);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!(pend.size() == 0 && m_ready[0] && m_ready[1] && m_ready[2]) && t < 200) begin
         cyc();
         t++;
      end
      chk("idle_timeout", 0, (t >= 200), 0);
   endtask

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 5))
         0:       return 8'h80;
         1:       return 8'h7F;
         2:       return 8'hFF;
         3:       return 8'h01;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();

      // unsigned with back-to-back start in the DONE cycle
      start(8'h0F, 8'h05, 1'b0);
      repeat (9) cyc();
      start(8'h35, 8'h05, 1'b0);
      chk("lit_done_k10", 0, done_w[0], 1);
      chk("lit_q_0f05",   0, q_w[0],    8'h03);
      chk("lit_r_0f05",   0, r_w[0],    8'h00);
      wait_idle();
      chk("lit_q_b2b",    0, q_w[0],    8'h0A);
      chk("lit_r_b2b",    0, r_w[0],    8'h03);
      chk("lit_q_b2b_u4", 2, q_w[2],    8'h0A);

      // signed
      start(8'h05, 8'hFD, 1'b1);
      wait_idle();
      chk("lit_q_s1", 0, q_w[0], 8'hFF);
      chk("lit_r_s1", 0, r_w[0], 8'h02);
      start(8'hF1, 8'h04, 1'b1);
      wait_idle();
      chk("lit_q_s2",  0, q_w[0],  8'hFD);
      chk("lit_r_s2",  0, r_w[0],  8'hFD);
      chk("lit_ov_s2", 0, ov_w[0], 0);
      start(8'h80, 8'hFF, 1'b1);
      wait_idle();
      chk("lit_q_minm1",  0, q_w[0],  8'h80);
      chk("lit_r_minm1",  0, r_w[0],  8'h00);
      chk("lit_ov_minm1", 0, ov_w[0], 1);

      // divide by zero: done one cycle after the trigger edge
      start(8'h80, 8'h00, 1'b0);
      cyc();
      chk("lit_done_dz", 0, done_w[0], 1);
      chk("lit_q_dz",    0, q_w[0],    8'hFF);
      chk("lit_r_dz",    0, r_w[0],    8'h80);
      chk("lit_dz",      0, dz_w[0],   1);
      wait_idle();

      // fixed point F=4 on inst 1
      start(8'h03, 8'h02, 1'b0);
      wait_idle();
      chk("lit_q_fp", 1, q_w[1], 8'h18);
      chk("lit_r_fp", 1, r_w[1], 8'h00);
      start(8'h20, 8'h01, 1'b0);
      wait_idle();
      chk("lit_ov_fp", 1, ov_w[1], 1);
      chk("lit_q_fpo", 1, q_w[1],  8'h00);

      // UNROLL=4 on inst 2: done after edge k+4
      start(8'h0F, 8'h05, 1'b0);
      repeat (4) cyc();
      chk("lit_done_u4", 2, done_w[2], 1);
      chk("lit_q_u4",    2, q_w[2],    8'h03);
      wait_idle();

      // reset in the middle of an operation
      start(8'h0F, 8'h05, 1'b0);
      repeat (3) cyc();
      rst = 1'b1;
      cyc();
      chk("lit_rst_ready", 0, ready_w[0], 1);
      chk("lit_rst_done",  0, done_w[0],  0);
      chk("lit_rst_q",     0, q_w[0],     8'h00);
      chk("lit_rst_r",     0, r_w[0],     8'h00);
      cyc();
      rst = 1'b0;
      repeat (12) cyc();
      start(8'h0F, 8'h05, 1'b0);
      wait_idle();
      chk("lit_q_after_rst", 0, q_w[0], 8'h03);

      // randomized traffic
      repeat (4000) begin
         if ($urandom_range(0, 599) == 0) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 2)) cyc();
            rst = 1'b0;
         end
         trigger    = ($urandom_range(0, 2) == 0);
         a          = pick();
         b          = ($urandom_range(0, 7) == 0) ? 8'h00 : pick();
         signed_cal = 1'($urandom_range(0, 1));
         cyc();
      end
      trigger = 1'b0;
      wait_idle();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 SHALL have parameter C_WIDTH, default 16: operand, quotient and remainder width, range 4..32.
REQ-002 SHALL have parameter FIXED_POINT, default 0: fractional bits F of the quotient, 0 <= F < C_WIDTH.
REQ-003 SHALL have parameter UNROLL, default 1: quotient bits resolved per cycle, one of 1/2/4, dividing C_WIDTH+F; ITER = (C_WIDTH+F)/UNROLL.
REQ-004 SHALL have port: ctl_clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port: trigger  in  1  start request, sampled when ready=1.
REQ-007 SHALL have port: a  in  C_WIDTH  dividend.
REQ-008 SHALL have port: b  in  C_WIDTH  divisor.
REQ-009 SHALL have port: signed_cal  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 SHALL have port: ready  out  1  able to accept trigger.
REQ-011 SHALL have port: done  out  1  one-cycle pulse, results valid.
REQ-012 SHALL have port: q  out  C_WIDTH  quotient.
REQ-013 SHALL have port: r  out  C_WIDTH  remainder.
REQ-014 SHALL have port: div_zero  out  1  last operation had b=0.
REQ-015 SHALL have port: overflow  out  1  last quotient did not fit in C_WIDTH.

Function
REQ-016 SHALL use states IDLE, CALC, FIX, DONE.
REQ-017 Transitions SHALL be: IDLE/DONE + trigger -> CALC (b!=0) or DONE (b=0); CALC -> FIX after ITER cycles; FIX -> DONE; DONE -> IDLE without trigger.
REQ-018 On an accepted trigger at edge k, the block SHALL register a, b and signed_cal; later input changes SHALL NOT affect the operation.
REQ-019 ready SHALL be 1 in IDLE and DONE, 0 in CALC and FIX; trigger while ready=0 SHALL be ignored.
REQ-020 For b!=0, done SHALL be 1 for exactly the cycle following edge k+ITER+2; q, r, div_zero, overflow SHALL update at that edge.
REQ-021 q, r, div_zero and overflow SHALL hold their values until the next done.
REQ-022 Trigger sampled in the DONE cycle SHALL start a new operation (back-to-back, no idle gap).
REQ-023 Core SHALL be restoring division on magnitudes, UNROLL quotient bits per CALC cycle, dividend extended by F zero LSBs.
REQ-024 Unsigned: q = low C_WIDTH bits of (a<<F)/b; r = (a<<F) mod b.
REQ-025 Signed: quotient truncates toward zero (negated in FIX if operand signs differ); r takes the sign of a, |r| < |b|.
REQ-026 overflow SHALL be 1 when the true quotient exceeds the C_WIDTH range (unsigned or signed as selected); q then holds its low C_WIDTH bits.
REQ-027 Signed min / -1 SHALL give q=min, r=0, overflow=1.
REQ-028 b=0 SHALL skip CALC; done one cycle after edge k; div_zero=1; r=a; q=all ones (unsigned), max positive (signed, a>=0), min negative (signed, a<0); overflow=0.
REQ-029 div_zero SHALL be 0 for every b!=0 operation.

Reset
REQ-030 reset SHALL force, asynchronously: state=IDLE, ready=1, done=0, q=0, r=0, div_zero=0, overflow=0.
REQ-031 reset asserted mid-operation SHALL abort it with no done pulse; the first trigger after deassertion SHALL be accepted.

Verification (C_WIDTH=8, UNROLL=1, F=0 unless stated; trigger at edge k)
REQ-032 Unsigned a=0x0F, b=0x05 -> done after edge k+10, q=0x03, r=0x00; back-to-back a=0x35, b=0x05 triggered in the DONE cycle -> q=0x0A, r=0x03.
REQ-033 Signed a=0x05, b=0xFD -> q=0xFF, r=0x02; signed a=0xF1, b=0x04 -> q=0xFD, r=0xFD; overflow=0.
REQ-034 Signed a=0x80, b=0xFF -> q=0x80, r=0x00, overflow=1; unsigned a=0x80, b=0x00 -> done after edge k+1, q=0xFF, r=0x80, div_zero=1.
REQ-035 F=4: unsigned a=0x03, b=0x02 -> q=0x18 (1.5), r=0x00, done after edge k+14; a=0x20, b=0x01 -> overflow=1, q=0x00.
REQ-036 UNROLL=4, F=0: a=0x0F, b=0x05 -> done after edge k+4, q=0x03.
REQ-037 reset pulsed 3 cycles after trigger -> no done, all outputs at reset values, ready=1; next trigger a=0x0F, b=0x05 -> q=0x03.
